rtc_bus_responder: RTL

RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

---
 rtl/rtc_bus_responder_pkg.sv | 37 +++
 rtl/rtc_bus_responder_bcd_step.sv | 30 +++
 rtl/rtc_bus_responder.sv | 114 +++++++++++
 3 files changed

// File: rtl/rtc_bus_responder_pkg.sv
// Shared constants for the RTC bus responder: register map, command bits, days-per-month table.
// Pure declarations; no logic and no latency.
package rtc_bus_responder_pkg;

  localparam logic [7:0] ADDR_SEC   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HOUR  = 8'h23;
  localparam logic [7:0] ADDR_DATE  = 8'h24;
  localparam logic [7:0] ADDR_MONTH = 8'h25;
  localparam logic [7:0] ADDR_YEAR  = 8'h26;
  localparam logic [7:0] ADDR_DOW   = 8'h27;
  localparam logic [7:0] ADDR_WEEK  = 8'h28;
  localparam logic [7:0] ADDR_TSEC  = 8'h41;
  localparam logic [7:0] ADDR_TMIN  = 8'h42;
  localparam logic [7:0] ADDR_THOUR = 8'h43;
  localparam logic [7:0] ADDR_CMD   = 8'hF0;

  localparam int CMD_RUN  = 0;
  localparam int CMD_HALT = 1;
  localparam int CMD_CLR  = 2;

  // Last BCD day per month, indexed by binary month; unused slots default to 31.
  localparam logic [15:0][7:0] DAYS_TBL = {
    8'h31, 8'h31, 8'h31, 8'h31, 8'h30, 8'h31, 8'h30, 8'h31,
    8'h31, 8'h30, 8'h31, 8'h30, 8'h31, 8'h28, 8'h31, 8'h31
  };

  function automatic logic [7:0] last_day(input logic [7:0] month, input logic [7:0] year);
    logic [3:0] idx;
    logic [7:0] ybin;
    idx  = month[4] ? (month[3:0] + 4'd10) : month[3:0];
    ybin = ({4'd0, year[7:4]} * 8'd10) + {4'd0, year[3:0]};
    last_day = DAYS_TBL[idx];
    if (idx == 4'd2 && ybin[1:0] == 2'b00) last_day = 8'h29;
  endfunction

endpackage

// File: rtl/rtc_bus_responder_bcd_step.sv
// One BCD increment/decrement with programmable wrap and reload values; combinational.
// cy flags the wrap (carry on increment, borrow on decrement).
module bcd_step
  import rtc_bus_responder_pkg::*;
(
  input  logic       en,
  input  logic       dec,
  input  logic [7:0] val,
  input  logic [7:0] wrap,
  input  logic [7:0] reload,
  output logic [7:0] nxt,
  output logic       cy
);

  always_comb begin
    nxt = val;
    cy  = 1'b0;
    if (en) begin
      if (val == wrap) begin
        nxt = reload;
        cy  = 1'b1;
      end else if (!dec) begin
        nxt = (val[3:0] == 4'd9) ? {val[7:4] + 4'd1, 4'd0} : val + 8'd1;
      end else begin
        nxt = (val[3:0] == 4'd0) ? {val[7:4] - 4'd1, 4'd9} : val - 8'd1;
      end
    end
  end

endmodule

// File: rtl/rtc_bus_responder.sv
// Real-time clock and countdown timer behind a multiplexed address/data host bus.
// Reads return one clk after the read condition; writes commit on the wr_n rising edge.
module rtc_bus_responder
  import rtc_bus_responder_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a_d,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       irq_n
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] pre_cnt;
  logic          tick, tick_c;
  logic [7:0]    sec, min, hour, date, month, year, dow, week;
  logic [7:0]    tmr_sec, tmr_min, tmr_hour, addr, rd_data, dim;
  logic [7:0]    sec_nx, min_nx, hour_nx, date_nx, month_nx, year_nx, dow_nx, week_nx;
  logic [7:0]    tsec_nx, tmin_nx, thour_nx;
  logic          c_sec, c_min, c_hour, c_date, c_month, c_dow, b_sec, b_min;
  logic          c_year_unused, c_week_unused, b_hour_unused;
  logic          run, halt, wr_q, wr_rise, addr_we, data_we, cmd_we;
  logic          tmr_en, expire, rd_cond;

  assign tick    = (pre_cnt == CW'(TICK_DIV - 1));
  assign tick_c  = tick & ~halt;
  assign wr_rise = wr_n & ~wr_q & ~cs_n;
  assign addr_we = wr_rise & ~a_d;
  assign data_we = wr_rise & a_d;
  assign cmd_we  = data_we && (addr == ADDR_CMD);
  assign rd_cond = ~cs_n & ~rd_n & a_d;
  assign dim     = last_day(month, year);

  // A zero timer is not decremented; it simply expires on the tick.
  assign tmr_en = tick_c & run & ({tmr_hour, tmr_min, tmr_sec} != 24'd0);
  assign expire = tick_c & run & ({thour_nx, tmin_nx, tsec_nx} == 24'd0);

  bcd_step u_sec   (.en(tick_c),  .dec(1'b0), .val(sec),   .wrap(8'h59), .reload(8'h00), .nxt(sec_nx),   .cy(c_sec));
  bcd_step u_min   (.en(c_sec),   .dec(1'b0), .val(min),   .wrap(8'h59), .reload(8'h00), .nxt(min_nx),   .cy(c_min));
  bcd_step u_hour  (.en(c_min),   .dec(1'b0), .val(hour),  .wrap(8'h23), .reload(8'h00), .nxt(hour_nx),  .cy(c_hour));
  bcd_step u_date  (.en(c_hour),  .dec(1'b0), .val(date),  .wrap(dim),   .reload(8'h01), .nxt(date_nx),  .cy(c_date));
  bcd_step u_month (.en(c_date),  .dec(1'b0), .val(month), .wrap(8'h12), .reload(8'h01), .nxt(month_nx), .cy(c_month));
  bcd_step u_year  (.en(c_month), .dec(1'b0), .val(year),  .wrap(8'h99), .reload(8'h00), .nxt(year_nx),  .cy(c_year_unused));
  bcd_step u_dow   (.en(c_hour),  .dec(1'b0), .val(dow),   .wrap(8'h07), .reload(8'h01), .nxt(dow_nx),   .cy(c_dow));
  bcd_step u_week  (.en(c_dow),   .dec(1'b0), .val(week),  .wrap(8'h52), .reload(8'h01), .nxt(week_nx),  .cy(c_week_unused));
  bcd_step u_tsec  (.en(tmr_en),  .dec(1'b1), .val(tmr_sec),  .wrap(8'h00), .reload(8'h59), .nxt(tsec_nx),  .cy(b_sec));
  bcd_step u_tmin  (.en(b_sec),   .dec(1'b1), .val(tmr_min),  .wrap(8'h00), .reload(8'h59), .nxt(tmin_nx),  .cy(b_min));
  bcd_step u_thour (.en(b_min),   .dec(1'b1), .val(tmr_hour), .wrap(8'h00), .reload(8'h23), .nxt(thour_nx), .cy(b_hour_unused));

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      ADDR_SEC:   rd_data = sec;
      ADDR_MIN:   rd_data = min;
      ADDR_HOUR:  rd_data = hour;
      ADDR_DATE:  rd_data = date;
      ADDR_MONTH: rd_data = month;
      ADDR_YEAR:  rd_data = year;
      ADDR_DOW:   rd_data = dow;
      ADDR_WEEK:  rd_data = week;
      ADDR_TSEC:  rd_data = tmr_sec;
      ADDR_TMIN:  rd_data = tmr_min;
      ADDR_THOUR: rd_data = tmr_hour;
      ADDR_CMD:   rd_data = {6'd0, halt, run};
      default:    rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      sec <= 8'h00; min <= 8'h00; hour <= 8'h00; date <= 8'h01;
      month <= 8'h01; year <= 8'h00; dow <= 8'h01; week <= 8'h01;
      tmr_sec <= 8'h00; tmr_min <= 8'h00; tmr_hour <= 8'h00;
      addr <= 8'h00; run <= 1'b0; halt <= 1'b0; wr_q <= 1'b1;
      irq_n <= 1'b1; ad_oe <= 1'b0; ad_out <= 8'h00;
    end else begin
      pre_cnt  <= tick ? '0 : pre_cnt + 1'b1;
      wr_q     <= wr_n;
      // Host data wins over the tick for the addressed field only.
      sec      <= (data_we && addr == ADDR_SEC)   ? ad_in : sec_nx;
      min      <= (data_we && addr == ADDR_MIN)   ? ad_in : min_nx;
      hour     <= (data_we && addr == ADDR_HOUR)  ? ad_in : hour_nx;
      date     <= (data_we && addr == ADDR_DATE)  ? ad_in : date_nx;
      month    <= (data_we && addr == ADDR_MONTH) ? ad_in : month_nx;
      year     <= (data_we && addr == ADDR_YEAR)  ? ad_in : year_nx;
      dow      <= (data_we && addr == ADDR_DOW)   ? ad_in : dow_nx;
      week     <= (data_we && addr == ADDR_WEEK)  ? ad_in : week_nx;
      tmr_sec  <= (data_we && addr == ADDR_TSEC)  ? ad_in : tsec_nx;
      tmr_min  <= (data_we && addr == ADDR_TMIN)  ? ad_in : tmin_nx;
      tmr_hour <= (data_we && addr == ADDR_THOUR) ? ad_in : thour_nx;
      if (addr_we) addr <= ad_in;
      if (cmd_we) begin
        run  <= ad_in[CMD_RUN];
        halt <= ad_in[CMD_HALT];
      end else if (expire) begin
        run <= 1'b0;
      end
      if (expire)                       irq_n <= 1'b0;
      else if (cmd_we && ad_in[CMD_CLR]) irq_n <= 1'b1;
      ad_oe  <= rd_cond;
      ad_out <= rd_cond ? rd_data : 8'h00;
    end
  end

endmodule
